// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline front end: fetch FSM encoding, PC step and
// default widths/reset values.
package cpu_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam int unsigned DEFAULT_CNT_W    = 32;

endpackage

// File: rtl/event_counter.sv
// Wrapping statistics counter with synchronous active-low clear; counts when both
// en and inc are high.
module event_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!clr_n) begin
      cnt_d = '0;
    end else if (en && inc) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, picks the next PC (halt, redirect, stall,
// sequential), runs the RUN/HALT FSM and keeps display statistics.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned ROM_AW   = 10,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              halt,
  input  logic [31:0]       halt_pc,
  input  logic              resume,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc_4,
  output logic [31:0]       if_ir,
  output logic              if_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  cnt_cycles,
  output logic [CNT_W-1:0]  cnt_stalls,
  output logic [CNT_W-1:0]  cnt_redirects
);

  fetch_state_t state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic         resume_d, resume_q;
  logic         resume_pulse;
  logic         running;
  logic [31:0]  pc_plus4;

  assign running      = (state_q == RUN);
  assign resume_pulse = resume & ~resume_q;
  assign pc_plus4     = pc_q + PC_STEP;

  // Halt outranks redirect: the halting instruction is older than the branch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    resume_d = resume;
    unique case (state_q)
      RUN: begin
        if (halt) begin
          state_d = HALT;
          pc_d    = halt_pc + PC_STEP;
        end else if (redirect) begin
          pc_d = {redirect_pc[31:2], 2'b00};
        end else if (!stall) begin
          pc_d = pc_plus4;
        end
      end
      HALT: begin
        if (resume_pulse) begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      resume_q <= resume_d;
    end
  end

  assign rom_addr = pc_q[ROM_AW+1:2];
  assign if_pc    = pc_q;
  assign if_pc_4  = pc_plus4;
  assign if_ir    = rom_data;
  assign if_valid = rst_n & running & ~redirect & ~halt;
  assign halted   = (state_q == HALT);

  event_counter #(
    .Width (CNT_W)
  ) u_cnt_cycles (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (running),
    .inc   (1'b1),
    .count (cnt_cycles)
  );

  event_counter #(
    .Width (CNT_W)
  ) u_cnt_stalls (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (running),
    .inc   (stall & ~redirect & ~halt),
    .count (cnt_stalls)
  );

  event_counter #(
    .Width (CNT_W)
  ) u_cnt_redirects (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (running),
    .inc   (redirect & ~halt),
    .count (cnt_redirects)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int unsigned RomAw = 10;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             halt;
  logic [31:0]      halt_pc;
  logic             resume;
  logic [RomAw-1:0] rom_addr;
  logic [31:0]      rom_data;
  logic [31:0]      if_pc;
  logic [31:0]      if_pc_4;
  logic [31:0]      if_ir;
  logic             if_valid;
  logic             halted;
  logic [31:0]      cnt_cycles;
  logic [31:0]      cnt_stalls;
  logic [31:0]      cnt_redirects;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .ROM_AW   (RomAw),
    .CNT_W    (32)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .halt_pc       (halt_pc),
    .resume        (resume),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .if_pc         (if_pc),
    .if_pc_4       (if_pc_4),
    .if_ir         (if_ir),
    .if_valid      (if_valid),
    .halted        (halted),
    .cnt_cycles    (cnt_cycles),
    .cnt_stalls    (cnt_stalls),
    .cnt_redirects (cnt_redirects)
  );

  // ROM contents are a simple tag over the word address.
  assign rom_data = 32'hC0DE_0000 | {22'd0, rom_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_rq;
  logic [31:0] m_cyc, m_st, m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit rd, input logic [31:0] rpc,
                       input bit h, input logic [31:0] hpc, input bit res);
    rst_n = r; stall = s; redirect = rd; redirect_pc = rpc;
    halt = h; halt_pc = hpc; resume = res;
  endtask

  task automatic check_model();
    logic [31:0] m_addr;
    m_addr = {20'd0, m_pc[11:2]};
    chk("if_pc", if_pc, m_pc);
    chk("if_pc_4", if_pc_4, m_pc + 32'd4);
    chk("rom_addr", {22'd0, rom_addr}, m_addr);
    chk("if_ir", if_ir, 32'hC0DE_0000 | m_addr);
    chk("if_valid", {31'd0, if_valid},
        {31'd0, rst_n & ~m_halted & ~redirect & ~halt});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("cnt_cycles", cnt_cycles, m_cyc);
    chk("cnt_stalls", cnt_stalls, m_st);
    chk("cnt_redirects", cnt_redirects, m_rd);
  endtask

  // Advance one clock and apply the fetch rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_pc = 32'h0; m_halted = 0; m_rq = 0;
      m_cyc = 0; m_st = 0; m_rd = 0;
    end else begin
      if (!m_halted) begin
        m_cyc = m_cyc + 1;
        if (halt) begin
          m_pc = halt_pc + 4;
          m_halted = 1;
        end else if (redirect) begin
          m_pc = redirect_pc & 32'hFFFF_FFFC;
          m_rd = m_rd + 1;
        end else if (stall) begin
          m_st = m_st + 1;
        end else begin
          m_pc = m_pc + 4;
        end
      end else if (resume && !m_rq) begin
        m_halted = 0;
      end
      m_rq = resume;
    end
    @(negedge clk);
  endtask

  typedef struct {
    bit          s;
    bit          rd;
    logic [31:0] rpc;
    bit          h;
    logic [31:0] hpc;
    bit          res;
    logic [31:0] e_pc;
    bit          e_valid;
    bit          e_halted;
  } vec_t;

  vec_t vecs[22];

  initial begin
    // Free run, stall, redirect-during-stall, halt-vs-redirect, resume, wrap.
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 32'h00, 1, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 32'h04, 1, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 32'h08, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 32'h0C, 1, 0};
    vecs[4]  = '{1, 0, 0, 0, 0, 0, 32'h10, 1, 0};
    vecs[5]  = '{1, 0, 0, 0, 0, 0, 32'h10, 1, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 32'h10, 1, 0};
    vecs[7]  = '{1, 1, 32'h43, 0, 0, 0, 32'h14, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 32'h40, 1, 0};
    vecs[9]  = '{0, 1, 32'h80, 1, 32'h20, 0, 32'h44, 0, 0};
    vecs[10] = '{1, 0, 0, 0, 0, 0, 32'h24, 0, 1};
    vecs[11] = '{0, 1, 32'h100, 0, 0, 0, 32'h24, 0, 1};
    vecs[12] = '{1, 1, 32'h200, 1, 32'h60, 0, 32'h24, 0, 1};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 32'h24, 0, 1};
    vecs[14] = '{1, 1, 32'h300, 0, 0, 0, 32'h24, 0, 1};
    vecs[15] = '{0, 0, 0, 0, 0, 1, 32'h24, 0, 1};
    vecs[16] = '{0, 0, 0, 0, 0, 1, 32'h24, 1, 0};
    vecs[17] = '{0, 0, 0, 0, 0, 1, 32'h28, 1, 0};
    vecs[18] = '{0, 0, 0, 0, 0, 0, 32'h2C, 1, 0};
    vecs[19] = '{0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'h30, 0, 0};
    vecs[20] = '{0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0};
    vecs[21] = '{0, 0, 0, 0, 0, 0, 32'h00, 1, 0};

    drive(0, 0, 0, 0, 0, 0, 0);
    m_pc = 0; m_halted = 0; m_rq = 0; m_cyc = 0; m_st = 0; m_rd = 0;
    @(negedge clk);
    tick();
    // Still in reset: outputs at reset values, if_valid gated by rst_n.
    #1;
    check_model();
    tick();

    for (int i = 0; i < 22; i++) begin
      drive(1, vecs[i].s, vecs[i].rd, vecs[i].rpc, vecs[i].h, vecs[i].hpc, vecs[i].res);
      #1;
      chk($sformatf("vec%0d.pc", i), if_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d.valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d.halted", i), {31'd0, halted}, {31'd0, vecs[i].e_halted});
      check_model();
      if (i == 4) chk("free_run_cycles", cnt_cycles, 32'd4);
      if (i == 20) chk("wrap_pc_4", if_pc_4, 32'h0);
      tick();
    end
    chk("stall_count", cnt_stalls, 32'd2);

    // Cycle counter wrap from all-ones.
    force u_dut.u_cnt_cycles.cnt_q = 32'hFFFF_FFFF;
    #1;
    release u_dut.u_cnt_cycles.cnt_q;
    m_cyc = 32'hFFFF_FFFF;
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("cyc_preload", cnt_cycles, 32'hFFFF_FFFF);
    tick();
    #1;
    chk("cyc_wrap", cnt_cycles, 32'h0);
    check_model();
    tick();

    // Reset while halted.
    drive(1, 0, 0, 0, 1, 32'h500, 0);
    #1; check_model(); tick();
    drive(0, 1, 1, 32'h700, 1, 32'h600, 1);
    #1;
    chk("halted_before_reset", {31'd0, halted}, 32'd1);
    check_model(); tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_cyc", cnt_cycles, 32'h0);
    chk("rst_st", cnt_stalls, 32'h0);
    chk("rst_rd", cnt_redirects, 32'h0);
    check_model();
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(49) != 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
            $urandom, $urandom_range(15) == 0, $urandom, $urandom_range(2) == 0);
      #1;
      check_model();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
